ad_scan_ctrl: RTL
=================

Name: ad_scan_ctrl

Overview:
Conversion sequencer and round-robin arbiter for the shared 8-bit AD converter (AD_block).
- Accepts level requests from NREQ requesters and grants the converter to one requester at a time.
- Issues a one-cycle start pulse, waits a fixed conversion latency, then captures the 8-bit result.
- Returns the result to the granted requester with a one-cycle done strobe.

Parameters:
NREQ, 4, number of requesters (2..8)
CONV_CYCLES, 3, cycles from ad_start to valid ad_data (>=1)
IDW, $clog2(NREQ), localparam, grant index width

Ports:
adck  in  1  system/converter clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NREQ  level request per requester; hold high until its done bit pulses
ad_data  in  8  result bus from AD_block out
ad_start  out  1  one-cycle conversion start to the converter
dout  out  8  captured result; valid when any done bit is high; held until next capture
done  out  NREQ  one-hot, one-cycle completion strobe to the granted requester
grant_id  out  IDW  index of the current/last granted requester
busy  out  1  high in START and CONV states

Behaviour:
- Reset (reset=0, async): state=IDLE, ad_start=0, done=0, dout=8'h00, grant_id=0, busy=0, last_grant=NREQ-1 so requester 0 wins first.
- FSM states: IDLE, START, CONV.
- IDLE, req!=0:
  - Round-robin pick: search from last_grant+1 upward, wrapping modulo NREQ; first set bit wins.
  - Register grant_id and go to START.
- IDLE, req==0: stay in IDLE.
- START: ad_start=1 for exactly this cycle; load counter=CONV_CYCLES-1; go to CONV.
- CONV: decrement counter. At counter==0 edge:
  - dout<=ad_data and done[grant_id]<=1 for one cycle.
  - last_grant<=grant_id; return to IDLE.
- Latency: req seen at edge E0 → ad_start high in cycle E0..E1 → done/dout valid after edge E(1+CONV_CYCLES).
- Throughput: one conversion per CONV_CYCLES+2 cycles while requests are pending.
- Request behaviour:
  - req sampled only in IDLE; changes during START/CONV do not affect the current grant.
  - Granted requester drops req mid-conversion: conversion completes, done still pulses, dout still updates.
  - Requester holding req high after done is re-arbitrated normally; others are served first if pending (no starvation).
  - All NREQ requesters asserting continuously are served 0,1,2,…,NREQ-1,0,… in strict rotation.
- Counter width is $clog2(CONV_CYCLES)+1; no wrap beyond 0.
- Reset asserted mid-conversion: immediate return to reset values; no done pulse for the aborted conversion.
- Outputs ad_start, done, dout, grant_id and busy are registered (no combinational paths from req).

Optional Feature:
Macro AD_SCAN_AVG_EN.
- Defined:
  - Each grant runs 4 back-to-back START/CONV pairs, accumulating ad_data into a 10-bit sum.
  - dout = sum[9:2] (truncating average); done pulses once, after the 4th capture.
  - busy stays high across all 4 conversions.
  - Latency becomes 4*(CONV_CYCLES+1) cycles after the grant edge.
- Undefined: single conversion per grant, as described above; no accumulator logic present.

Decomposition:
- Shared package ad_pkg: FSM state encoding (IDLE/START/CONV), AD_W=8 data width, AVG_N=4 and AVG_SHIFT=2 constants.
- One sub-module: ad_rr_arbiter (combinational round-robin pick from req and last_grant → grant index and valid).
- Counter, FSM and capture register live in ad_scan_ctrl.

Test Plan:
- Reset release, req=4'b0000 for 20 cycles → ad_start never pulses, done=0, dout=8'h00, busy=0.
- req=4'b0100, CONV_CYCLES=3, model returns 8'hA5 → one ad_start pulse, grant_id=2; done=4'b0100 exactly 4 cycles after the ad_start cycle; dout=8'hA5 and held.
- req=4'b1111 held → grant order 0,1,2,3,0 with done pulses spaced 5 cycles apart; each requester's dout matches model values 8'h10, 8'h20, 8'h30, 8'h40.
- req[1] dropped mid-conversion → done=4'b0010 still pulses; the next grant goes to a still-pending requester.
- reset driven low during CONV → all outputs reset asynchronously (no clock needed); no done pulse; after release, requester 0 is granted first.
- AD_SCAN_AVG_EN defined, model returns 8'h10, 8'h20, 8'h30, 8'h41 → four ad_start pulses, a single done pulse, dout=8'h28.

Source files
------------

// File: rtl/ad_pkg.sv
// Shared types and constants for the AD scan controller: FSM encoding,
// converter data width and averaging constants.
package ad_pkg;

  localparam int unsigned AD_W      = 8;
  localparam int unsigned AVG_N     = 4;
  localparam int unsigned AVG_SHIFT = 2;
  localparam int unsigned ACC_W     = AD_W + AVG_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_CONV  = 2'd2
  } ad_state_e;

endpackage

// File: rtl/ad_scan_ctrl_if.sv
// Requester/converter-facing bundle of the AD scan controller.
// master = requesters + converter side, slave = the controller.
interface ad_scan_ctrl_if #(
  parameter int unsigned NREQ = 4
) ();
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]         req;
  logic [ad_pkg::AD_W-1:0] ad_data;
  logic                    ad_start;
  logic [ad_pkg::AD_W-1:0] dout;
  logic [NREQ-1:0]         done;
  logic [IDW-1:0]          grant_id;
  logic                    busy;

  modport master (
    output req,
    output ad_data,
    input  ad_start,
    input  dout,
    input  done,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req,
    input  ad_data,
    output ad_start,
    output dout,
    output done,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/ad_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after last_grant+1,
// wrapping modulo NREQ.
module ad_rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  pick_c,
  output logic            valid_c
);

  logic [IDW-1:0] idx;

  always_comb begin
    pick_c  = '0;
    valid_c = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDW'((32'(last_grant) + i) % NREQ);
      if (!valid_c && req[idx]) begin
        pick_c  = idx;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad_scan_ctrl.sv
// Conversion sequencer and round-robin arbiter for the shared 8-bit converter.
// Define AD_SCAN_AVG_EN to run 4 conversions per grant and return their average.
module ad_scan_ctrl
  import ad_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned CONV_CYCLES = 3
) (
  input logic          adck,
  input logic          reset,
  ad_scan_ctrl_if.slave bus
);

  localparam int unsigned IDW   = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(CONV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  ad_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDW-1:0]    last_grant_q;
  logic [IDW-1:0]    grant_id_q;
  logic              ad_start_q;
  logic [NREQ-1:0]   done_q;
  logic [AD_W-1:0]   dout_q;
  logic              busy_q;

  logic [IDW-1:0]    arb_pick_c;
  logic              arb_valid_c;

`ifdef AD_SCAN_AVG_EN
  localparam int unsigned PASS_W = $clog2(AVG_N);
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_sum_c;
  logic [PASS_W-1:0] pass_q;

  assign acc_sum_c = acc_q + ACC_W'(bus.ad_data);
`endif

  ad_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .pick_c     (arb_pick_c),
    .valid_c    (arb_valid_c)
  );

  // Sequencer: grant in IDLE, pulse start, count down the conversion, capture.
  always_ff @(posedge adck or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      grant_id_q   <= '0;
      ad_start_q   <= 1'b0;
      done_q       <= '0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
`ifdef AD_SCAN_AVG_EN
      acc_q        <= '0;
      pass_q       <= '0;
`endif
    end else begin
      ad_start_q <= 1'b0;
      done_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid_c) begin
            grant_id_q <= arb_pick_c;
            ad_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
`ifdef AD_SCAN_AVG_EN
            acc_q      <= '0;
            pass_q     <= '0;
`endif
          end
        end
        ST_START: begin
          cnt_q   <= CNT_LOAD;
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
`ifdef AD_SCAN_AVG_EN
            if (pass_q == PASS_W'(AVG_N - 1)) begin
              dout_q       <= AD_W'(acc_sum_c >> AVG_SHIFT);
              done_q       <= NREQ'(1) << grant_id_q;
              last_grant_q <= grant_id_q;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              acc_q      <= acc_sum_c;
              pass_q     <= pass_q + PASS_W'(1);
              ad_start_q <= 1'b1;
              state_q    <= ST_START;
            end
`else
            dout_q       <= bus.ad_data;
            done_q       <= NREQ'(1) << grant_id_q;
            last_grant_q <= grant_id_q;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ad_start = ad_start_q;
  assign bus.done     = done_q;
  assign bus.dout     = dout_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

endmodule
